// File: rtl/fx2_ep_scheduler.sv
// Round-robin arbiter for the FX2 slave-FIFO bus across EP2/EP4 (OUT) and EP6/EP8 (IN).
// Grants one endpoint, waits out address turnaround, then strobes a bounded byte burst.
module fx2_ep_scheduler #(
    parameter int BURST_LEN  = 16,
    parameter int TURNAROUND = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       usb_ep2_empty,
    input  logic       usb_ep4_empty,
    input  logic       usb_ep6_full,
    input  logic       usb_ep8_full,
    input  logic [1:0] sink_ready,
    input  logic [1:0] src_valid,
    input  logic [3:0] ep_enable,
    output logic [1:0] usb_addr,
    output logic [3:0] grant,
    output logic       xfer,
    output logic       xfer_dir,
    output logic       busy,
    output logic [7:0] burst_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);
    localparam logic [2:0] TURN_C      = 3'(TURNAROUND);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] elig_s;
    logic [1:0] last_r;
    logic [1:0] win_s;
    logic [1:0] cand_s;
    logic       found_s;
    logic [1:0] addr_r;
    logic [3:0] grant_r;
    logic       dir_r;
    logic [7:0] count_r;
    logic [2:0] turn_r;
    logic       xfer_s;
    logic       busy_s;
    logic       burst_done_s;

    assign elig_s = {ep_enable[3] & ~usb_ep8_full  & src_valid[1],
                     ep_enable[2] & ~usb_ep6_full  & src_valid[0],
                     ep_enable[1] & ~usb_ep4_empty & sink_ready[1],
                     ep_enable[0] & ~usb_ep2_empty & sink_ready[0]};

    assign found_s      = |elig_s;
    assign burst_done_s = ((count_r + 8'd1) == BURST_LEN_C);

    // Round-robin pick: scan from last+4 down to last+1 so the nearest successor of last wins.
    always_comb begin
        win_s  = 2'd0;
        cand_s = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand_s = last_r + 2'(k);
            win_s  = elig_s[cand_s] ? cand_s : win_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!found_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (win_s == addr_r) begin
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (turn_r == 3'd1) begin
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_SETUP;
                end
            end
            ST_XFER: begin
                if (!elig_s[addr_r] || burst_done_s) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            ST_RELEASE: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: strobe follows live eligibility so a flag drop cuts it the same cycle.
    always_comb begin
        xfer_s = 1'b0;
        busy_s = 1'b1;
        case (state_r)
            ST_IDLE:  busy_s = 1'b0;
            ST_XFER:  xfer_s = elig_s[addr_r];
            default:  xfer_s = 1'b0;
        endcase
    end

    // Grant, address, burst and turnaround bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_r  <= 2'd0;
            grant_r <= 4'd0;
            dir_r   <= 1'b0;
            count_r <= 8'd0;
            turn_r  <= 3'd0;
            last_r  <= 2'b11;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        addr_r  <= win_s;
                        grant_r <= 4'b0001 << win_s;
                        dir_r   <= win_s[1];
                        count_r <= 8'd0;
                        turn_r  <= TURN_C;
                    end
                end
                ST_SETUP: turn_r <= turn_r - 3'd1;
                ST_XFER: begin
                    if (xfer_s) begin
                        count_r <= count_r + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    grant_r <= 4'd0;
                    last_r  <= addr_r;
                end
                default: grant_r <= 4'd0;
            endcase
        end
    end

    assign usb_addr    = addr_r;
    assign grant       = grant_r;
    assign xfer        = xfer_s;
    assign xfer_dir    = dir_r;
    assign busy        = busy_s;
    assign burst_count = count_r;

endmodule

// File: tb/tb_fx2_ep_scheduler.sv
// Scoreboard bench for fx2_ep_scheduler: stimulus queues expected strobes and burst ends,
// a negedge monitor pops and compares them against two instances (BURST_LEN 16 and 1).
module tb_fx2_ep_scheduler;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  addr;
        logic [7:0]  cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full;
    logic [1:0] sink_ready, src_valid;
    logic [3:0] ep_enable_a, ep_enable_b;

    logic [1:0] usb_addr_a, usb_addr_b;
    logic [3:0] grant_a, grant_b;
    logic       xfer_a, xfer_b, xfer_dir_a, xfer_dir_b, busy_a, busy_b;
    logic [7:0] burst_count_a, burst_count_b;

    logic [3:0]  prev_grant_a = 4'd0;
    logic [3:0]  prev_grant_b = 4'd0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    exp_t sq_a[$];
    exp_t bq_a[$];
    exp_t sq_b[$];
    exp_t bq_b[$];

    fx2_ep_scheduler #(.BURST_LEN(16), .TURNAROUND(2)) dut_a (
        .clk(clk), .reset(reset),
        .usb_ep2_empty(usb_ep2_empty), .usb_ep4_empty(usb_ep4_empty),
        .usb_ep6_full(usb_ep6_full), .usb_ep8_full(usb_ep8_full),
        .sink_ready(sink_ready), .src_valid(src_valid), .ep_enable(ep_enable_a),
        .usb_addr(usb_addr_a), .grant(grant_a), .xfer(xfer_a), .xfer_dir(xfer_dir_a),
        .busy(busy_a), .burst_count(burst_count_a)
    );

    fx2_ep_scheduler #(.BURST_LEN(1), .TURNAROUND(2)) dut_b (
        .clk(clk), .reset(reset),
        .usb_ep2_empty(usb_ep2_empty), .usb_ep4_empty(usb_ep4_empty),
        .usb_ep6_full(usb_ep6_full), .usb_ep8_full(usb_ep8_full),
        .sink_ready(sink_ready), .src_valid(src_valid), .ep_enable(ep_enable_b),
        .usb_addr(usb_addr_b), .grant(grant_b), .xfer(xfer_b), .xfer_dir(xfer_dir_b),
        .busy(busy_b), .burst_count(burst_count_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp_v);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_strobes(input int i, input int unsigned first, input logic [1:0] addr,
                                input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.cyc  = first + 32'(k);
            e.addr = addr;
            e.cnt  = 8'(k);
            if (i == 0) sq_a.push_back(e);
            else        sq_b.push_back(e);
        end
    endtask

    task automatic push_end(input int i, input int unsigned at, input logic [1:0] addr,
                            input logic [7:0] cnt);
        exp_t e;
        e.cyc  = at;
        e.addr = addr;
        e.cnt  = cnt;
        if (i == 0) bq_a.push_back(e);
        else        bq_b.push_back(e);
    endtask

    // Field layout in strobe/end compares: cycle | addr | grant | dir | count
    task automatic mon_step(input int i, input logic xf, input logic [1:0] ad,
                            input logic [3:0] gr, input logic dr, input logic [7:0] bc,
                            input logic [3:0] pg);
        exp_t e;
        int   n;
        if (xf) begin
            n = (i == 0) ? sq_a.size() : sq_b.size();
            if (n == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe dut%0d: strobe at cycle %0d addr %0d, required none",
                         i, cyc, ad);
            end else begin
                if (i == 0) e = sq_a.pop_front();
                else        e = sq_b.pop_front();
                chk($sformatf("strobe dut%0d", i), {cyc, 4'(ad), gr, 4'(dr), bc},
                    {e.cyc, 4'(e.addr), 4'b0001 << e.addr, 4'(e.addr[1]), e.cnt});
            end
        end
        if (pg != 4'd0 && gr == 4'd0) begin
            n = (i == 0) ? bq_a.size() : bq_b.size();
            if (n == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_release dut%0d: grant dropped at cycle %0d, required none",
                         i, cyc);
            end else begin
                if (i == 0) e = bq_a.pop_front();
                else        e = bq_b.pop_front();
                chk($sformatf("burst_end dut%0d", i), {cyc, 4'(ad), 4'd0, 4'd0, bc},
                    {e.cyc, 4'(e.addr), 4'd0, 4'd0, e.cnt});
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, xfer_a, usb_addr_a, grant_a, xfer_dir_a, burst_count_a, prev_grant_a);
        mon_step(1, xfer_b, usb_addr_b, grant_b, xfer_dir_b, burst_count_b, prev_grant_b);
        prev_grant_a <= grant_a;
        prev_grant_b <= grant_b;
    end

    task automatic drain(input string nm);
        chk({nm, " pending"}, 64'(sq_a.size() + bq_a.size() + sq_b.size() + bq_b.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wait_cyc(2);
        chk("reset_state a", {grant_a, 4'(usb_addr_a), 4'(xfer_a), 4'(xfer_dir_a), 4'(busy_a),
                              burst_count_a}, 64'd0);
        chk("reset_state b", {grant_b, 4'(usb_addr_b), 4'(xfer_b), 4'(xfer_dir_b), 4'(busy_b),
                              burst_count_b}, 64'd0);
        reset = 1'b1;
    endtask

    initial begin
        int unsigned c0;
        reset         = 1'b0;
        usb_ep2_empty = 1'b0;
        usb_ep4_empty = 1'b0;
        usb_ep6_full  = 1'b0;
        usb_ep8_full  = 1'b0;
        sink_ready    = 2'b11;
        src_valid     = 2'b11;
        ep_enable_a   = 4'b0000;
        ep_enable_b   = 4'b0000;
        do_reset();

        // EP2 alone right after reset: no setup, 16 strobes, grant drops at c0+18.
        c0 = cyc;
        ep_enable_a = 4'b0001;
        push_strobes(0, c0 + 1, 2'd0, 16);
        push_end(0, c0 + 18, 2'd0, 8'd16);
        wait_cyc(17);
        ep_enable_a = 4'b0000;
        wait_cyc(4);
        drain("ep2_only");

        // All four eligible: EP2, EP4, EP6, EP8, EP2 with two setup cycles per address change.
        do_reset();
        c0 = cyc;
        ep_enable_a = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_strobes(0, c0 + 1 + 32'(20 * k), 2'(k), 16);
            push_end(0, c0 + 18 + 32'(20 * k), 2'(k), 8'd16);
        end
        wait_cyc(97);
        ep_enable_a = 4'b0000;
        wait_cyc(4);
        drain("round_robin");

        // EP6 stalls after byte 5; EP8 must win over EP2, then a mid-burst disable ends it.
        c0 = cyc;
        ep_enable_a = 4'b0100;
        push_strobes(0, c0 + 3, 2'd2, 5);
        push_end(0, c0 + 10, 2'd2, 8'd5);
        wait_cyc(8);
        usb_ep6_full = 1'b1;
        ep_enable_a  = 4'b1101;
        push_strobes(0, c0 + 13, 2'd3, 2);
        push_end(0, c0 + 17, 2'd3, 8'd2);
        wait_cyc(7);
        ep_enable_a  = 4'b0000;
        usb_ep6_full = 1'b0;
        wait_cyc(4);
        drain("ep6_stall");

        // EP4 disabled during setup: no strobe, release with count 0.
        c0 = cyc;
        ep_enable_a = 4'b0010;
        push_end(0, c0 + 5, 2'd1, 8'd0);
        wait_cyc(1);
        ep_enable_a = 4'b0000;
        wait_cyc(6);
        drain("setup_disable");

        // Reset during byte 3 of an EP8 burst, then EP2 has priority over EP8.
        c0 = cyc;
        ep_enable_a = 4'b1000;
        push_strobes(0, c0 + 3, 2'd3, 3);
        push_end(0, c0 + 6, 2'd0, 8'd0);
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(1);
        chk("reset_midburst", {grant_a, 4'(usb_addr_a), 4'(xfer_a), 4'(busy_a)}, 64'd0);
        reset = 1'b1;
        ep_enable_a = 4'b1001;
        push_strobes(0, c0 + 7, 2'd0, 1);
        push_end(0, c0 + 10, 2'd0, 8'd1);
        wait_cyc(2);
        ep_enable_a = 4'b0000;
        wait_cyc(4);
        drain("reset_midburst");

        // BURST_LEN=1 instance, EP2 and EP6 alternately eligible: one strobe per grant.
        c0 = cyc;
        ep_enable_b = 4'b0001;
        push_strobes(1, c0 + 1, 2'd0, 1);
        push_end(1, c0 + 3, 2'd0, 8'd1);
        wait_cyc(2);
        ep_enable_b = 4'b0100;
        push_strobes(1, c0 + 6, 2'd2, 1);
        push_end(1, c0 + 8, 2'd2, 8'd1);
        wait_cyc(5);
        ep_enable_b = 4'b0001;
        push_strobes(1, c0 + 11, 2'd0, 1);
        push_end(1, c0 + 13, 2'd0, 8'd1);
        wait_cyc(5);
        ep_enable_b = 4'b0100;
        push_strobes(1, c0 + 16, 2'd2, 1);
        push_end(1, c0 + 18, 2'd2, 8'd1);
        wait_cyc(5);
        ep_enable_b = 4'b0000;
        wait_cyc(4);
        drain("burst_len_1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fx2_ep_scheduler.md
# fx2_ep_scheduler

Round-robin scheduler that shares the single FX2 slave-FIFO bus between endpoints EP2, EP4, EP6 and EP8. It selects the next endpoint that can move data and drives the FIFO address. It inserts address-setup turnaround, then issues a bounded burst of byte strobes. It sits between the FX2 flag pins and the FX2 interface glue logic, which converts `xfer`/`xfer_dir` into `usb_slrd`/`usb_slwr` and routes data.

## Interface
Parameters:
- `BURST_LEN`, 16: maximum bytes per grant, legal range 1..255.
- `TURNAROUND`, 2: idle cycles between an address change and the first strobe, legal range 1..7.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `usb_ep2_empty`, `usb_ep4_empty`  in  1 each  FX2 OUT-endpoint empty flags.
- `usb_ep6_full`, `usb_ep8_full`  in  1 each  FX2 IN-endpoint full flags.
- `sink_ready`  in  2  [0] DAC buffer accepts an EP2 byte; [1] command decoder accepts an EP4 byte.
- `src_valid`  in  2  [0] ADC byte available for EP6; [1] status byte available for EP8.
- `ep_enable`  in  4  per-endpoint enable mask; bit order EP2, EP4, EP6, EP8.
- `usb_addr`  out  2  FX2 FIFO address: 00=EP2, 01=EP4, 10=EP6, 11=EP8.
- `grant`  out  4  one-hot endpoint currently owning the bus; same bit order as `ep_enable`.
- `xfer`  out  1  one byte moves on the granted endpoint this cycle.
- `xfer_dir`  out  1  0 = read from FX2 (EP2/EP4); 1 = write to FX2 (EP6/EP8).
- `busy`  out  1  high in every state except IDLE.
- `burst_count`  out  8  bytes moved in the current burst, or in the most recent burst.

## Operation
- Eligibility, evaluated combinationally each cycle:
  - e0 = `ep_enable[0]` & !`usb_ep2_empty` & `sink_ready[0]`
  - e1 = `ep_enable[1]` & !`usb_ep4_empty` & `sink_ready[1]`
  - e2 = `ep_enable[2]` & !`usb_ep6_full` & `src_valid[0]`
  - e3 = `ep_enable[3]` & !`usb_ep8_full` & `src_valid[1]`
- `last` register (2 bits) records the most recently granted endpoint. Search order is `last`+1, `last`+2, `last`+3, `last` (mod 4). The first eligible endpoint in that order wins.
- States:
  - IDLE: if no endpoint is eligible, stay in IDLE. Otherwise latch the winner `idx`, set `grant`, `usb_addr`<=`idx`, `xfer_dir`<=`idx[1]`, and clear `burst_count`.
    - If `idx` differs from the current `usb_addr`, load the turnaround counter with TURNAROUND and go to SETUP.
    - If `idx` equals the current `usb_addr`, go directly to XFER.
  - SETUP: decrement the counter each cycle. Go to XFER in the cycle the counter reaches 1.
  - XFER: `xfer` = e[`idx`], combinational, so a flag drop stops the strobe in the same cycle. Each cycle with `xfer`=1 increments `burst_count`.
    - Go to RELEASE after the cycle in which `burst_count` reaches BURST_LEN.
    - Go to RELEASE immediately if e[`idx`]=0; a stall ends the burst.
  - RELEASE: one cycle. `grant`<=0 and `last`<=`idx`, then go to IDLE. `usb_addr` and `burst_count` hold their values.
- `xfer` is 0 in every state except XFER.
- Width rule: `burst_count` never exceeds BURST_LEN. Comparison is 8-bit unsigned.

## Timing
- Reset values (reset=0 at a clock edge): state IDLE, `usb_addr`=00, `grant`=0000, `xfer`=0, `xfer_dir`=0, `busy`=0, `burst_count`=0, `last`=11. With `last`=11, EP2 has first priority.
- Arbitration decision: eligibility sampled in IDLE at edge N gives `grant` and `usb_addr` valid from N+1.
- First strobe at N+1+TURNAROUND when the address changes; at N+1 when the address is unchanged.
- Minimum gap between bursts: RELEASE plus IDLE gives 2 cycles with no strobe.
- Simultaneous eligibility: round-robin order decides; no endpoint is granted twice while another eligible endpoint waits.
- `ep_enable` bit cleared mid-burst: `xfer` drops in the same cycle and the state goes to RELEASE.
- Flags changing during SETUP are ignored. If the endpoint is ineligible on entry to XFER, that XFER cycle has no strobe and the state goes to RELEASE with `burst_count`=0.
- Reset asserted in any state: outputs return to reset values at that edge. An in-flight burst is abandoned with no further strobe.

## Test plan
- After reset, EP2 only eligible, BURST_LEN=16: `grant`=0001 from cycle 1; `xfer` high for cycles 1..16 (address unchanged, no SETUP); RELEASE at 17; `burst_count`=16.
- All four eligible continuously, TURNAROUND=2: grants in order EP2, EP4, EP6, EP8, EP2. Each address change shows 2 strobe-free SETUP cycles and `usb_addr` follows 00, 01, 10, 11, 00.
- EP6 granted and `usb_ep6_full` rises after byte 5: `xfer` falls in that same cycle, `burst_count`=5, next grant goes to the next eligible endpoint after EP6.
- EP4 eligible, `ep_enable[1]` cleared during SETUP: no strobe occurs, `burst_count`=0, return to IDLE via RELEASE.
- reset=0 driven during byte 3 of an EP8 burst: at that edge `grant`=0000, `xfer`=0, `usb_addr`=00, `busy`=0; the next grant after release starts at EP2.
- BURST_LEN=1 with EP2 and EP6 alternately eligible: exactly one strobe per grant, `burst_count`=1 after each.
